// File: rtl/mac_pkg.sv
// Shared types, default widths and saturation limits for the MAC accumulator.
package mac_pkg;

    typedef enum logic [1:0] {
        ACCUM = 2'd0,
        DRAIN = 2'd1,
        HOLD  = 2'd2
    } mac_state_t;

    localparam int MAC_ACC_W = 40;
    localparam int MAC_CNT_W = 8;

    function automatic logic signed [63:0] acc_max(input int w);
        return (64'sd1 <<< (w - 1)) - 64'sd1;
    endfunction

    function automatic logic signed [63:0] acc_min(input int w);
        return -(64'sd1 <<< (w - 1));
    endfunction

endpackage

// File: rtl/Signed_Multiplier.sv
// Combinational 16x16 signed multiplier, full 32-bit product.
// Latency: 0 cycles. Backpressure: none, pure logic.
module Signed_Multiplier (
    input  logic signed [15:0] A,
    input  logic signed [15:0] B,
    output logic signed [31:0] P
);

    assign P = A * B;

endmodule

// File: rtl/mac_accumulator.sv
// Signed dot-product MAC: registered product, wide accumulate per `last`-delimited vector.
// Latency: result valid 2 cycles after the last beat; one beat per cycle within a vector.
// Backpressure: in_ready low in DRAIN/HOLD; result held stable until out_ready (MAC_SATURATE_EN clamps acc).
module mac_accumulator
    import mac_pkg::*;
#(
    parameter int ACC_W = MAC_ACC_W,
    parameter int CNT_W = MAC_CNT_W
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic signed [15:0]      a,
    input  logic signed [15:0]      b,
    input  logic                    last,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic signed [ACC_W-1:0] acc_out,
    output logic [CNT_W-1:0]        count,
    output logic                    overflow
);

    mac_state_t              state_q, state_d;
    logic signed [31:0]      prod;
    logic signed [31:0]      p_q, p_d;
    logic                    p_vld_q, p_vld_d;
    logic signed [ACC_W-1:0] acc_q, acc_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic                    ovf_q, ovf_d;
    logic                    first_q, first_d;
    logic                    accept;
    logic [ACC_W:0]          base_ext;
    logic [ACC_W:0]          p_ext;
    logic [ACC_W:0]          sum;
    logic                    add_ovf;

    Signed_Multiplier u_mult (
        .A (a),
        .B (b),
        .P (prod)
    );

    assign in_ready  = (state_q == ACCUM);
    assign out_valid = (state_q == HOLD);
    assign acc_out   = acc_q;
    assign count     = cnt_q;
    assign overflow  = ovf_q;
    assign accept    = in_valid && in_ready;

    // One guard bit above ACC_W: overflow shows as the top two sum bits disagreeing.
    assign base_ext = first_q ? '0 : {acc_q[ACC_W-1], acc_q};
    assign p_ext    = {{(ACC_W + 1 - 32){p_q[31]}}, p_q};
    assign sum      = base_ext + p_ext;
    assign add_ovf  = sum[ACC_W] ^ sum[ACC_W-1];

    always_comb begin
        state_d = state_q;
        p_d     = p_q;
        p_vld_d = 1'b0;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        ovf_d   = ovf_q;
        first_d = first_q;

        if (accept) begin
            p_d     = prod;
            p_vld_d = 1'b1;
        end

        if (p_vld_q) begin
`ifdef MAC_SATURATE_EN
            if (add_ovf)
                acc_d = sum[ACC_W] ? ACC_W'(acc_min(ACC_W)) : ACC_W'(acc_max(ACC_W));
            else
                acc_d = sum[ACC_W-1:0];
`else
            acc_d = sum[ACC_W-1:0];
`endif
            cnt_d   = (cnt_q == '1) ? cnt_q : cnt_q + 1'b1;
            ovf_d   = ovf_q | add_ovf;
            first_d = 1'b0;
        end

        case (state_q)
            ACCUM: if (accept && last) state_d = DRAIN;
            DRAIN: state_d = HOLD;
            HOLD: begin
                // No stage-2 add can be pending here, so the clears never collide with one.
                if (out_ready) begin
                    state_d = ACCUM;
                    first_d = 1'b1;
                    cnt_d   = '0;
                    ovf_d   = 1'b0;
                end
            end
            default: state_d = ACCUM;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ACCUM;
            p_q     <= '0;
            p_vld_q <= 1'b0;
            acc_q   <= '0;
            cnt_q   <= '0;
            ovf_q   <= 1'b0;
            first_q <= 1'b1;
        end else begin
            state_q <= state_d;
            p_q     <= p_d;
            p_vld_q <= p_vld_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            ovf_q   <= ovf_d;
            first_q <= first_d;
        end
    end

endmodule

// File: tb/tb_mac_accumulator.sv
// Scoreboard bench for mac_accumulator: driver pushes model results, negedge monitor pops and compares.
module tb_mac_accumulator;

    localparam int ACC_W = 40;
    localparam int CNT_W = 8;
    localparam longint AMAX = (64'sd1 <<< (ACC_W - 1)) - 1;
    localparam longint AMIN = -(64'sd1 <<< (ACC_W - 1));
    localparam longint CMAX = (1 << CNT_W) - 1;

    logic                    clk = 1'b0;
    logic                    rst_n = 1'b0;
    logic                    in_valid = 1'b0;
    logic                    in_ready;
    logic signed [15:0]      a = '0;
    logic signed [15:0]      b = '0;
    logic                    last = 1'b0;
    logic                    out_valid;
    logic                    out_ready = 1'b0;
    logic signed [ACC_W-1:0] acc_out;
    logic [CNT_W-1:0]        count;
    logic                    overflow;

    mac_accumulator #(.ACC_W(ACC_W), .CNT_W(CNT_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .last      (last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .acc_out   (acc_out),
        .count     (count),
        .overflow  (overflow)
    );

    always #5 clk = ~clk;

    typedef struct {
        longint acc;
        longint cnt;
        longint ovf;
        int     cyc;
    } exp_t;

    exp_t   sb[$];
    shortint vec_a[$];
    shortint vec_b[$];
    int     errors = 0;
    int     checks = 0;
    int     cyc = 0;
    int     hs_cyc = -100;
    bit     force_stall = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input longint act, input longint req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", nm, act, req, cyc);
        end
    endtask

    always @(posedge clk) begin
        #1;
        out_ready = force_stall ? 1'b0 : ($urandom_range(0, 3) != 0);
    end

    // Monitor: latency on rising out_valid, stability while stalled, compare at handshake.
    bit     prev_vld = 1'b0;
    longint snap_acc, snap_cnt, snap_ovf;
    always @(negedge clk) begin
        if (!rst_n) begin
            prev_vld = 1'b0;
        end else begin
            if (out_valid) begin
                chk("in_ready_low_in_hold", longint'(in_ready), 0);
                if (!prev_vld) begin
                    if (sb.size() == 0)
                        chk("unexpected_result", 1, 0);
                    else
                        chk("latency", cyc, sb[0].cyc + 2);
                    snap_acc = longint'(acc_out);
                    snap_cnt = longint'(count);
                    snap_ovf = longint'(overflow);
                end else begin
                    chk("stable_acc", longint'(acc_out), snap_acc);
                    chk("stable_count", longint'(count), snap_cnt);
                    chk("stable_overflow", longint'(overflow), snap_ovf);
                end
                if (out_ready && sb.size() != 0) begin
                    exp_t e;
                    e = sb.pop_front();
                    chk("acc_out", longint'(acc_out), e.acc);
                    chk("count", longint'(count), e.cnt);
                    chk("overflow", longint'(overflow), e.ovf);
                    hs_cyc = cyc;
                end
            end
            prev_vld = out_valid && !out_ready;
        end
    end

    task automatic send_beat(input shortint av, input shortint bv, input bit lst, output int acc_cyc);
        int w;
        in_valid = 1'b1;
        a = av;
        b = bv;
        last = lst;
        w = 0;
        @(negedge clk);
        while (!in_ready && w < 300) begin
            @(negedge clk);
            w++;
        end
        if (!in_ready) begin
            chk("accept_timeout", 0, 1);
            acc_cyc = -1;
        end else begin
            acc_cyc = cyc;
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        last = 1'b0;
    endtask

    // Reference model: plain arithmetic over the whole vector, then drive beats.
    task automatic run_vector(input bit gaps, output int first_cyc);
        longint acc = 0, s, p;
        longint cnt = 0, ov = 0;
        int     c, c0;
        exp_t   e;
        foreach (vec_a[i]) begin
            p = longint'(vec_a[i]) * longint'(vec_b[i]);
            s = acc + p;
            if (s > AMAX || s < AMIN) begin
                ov = 1;
`ifdef MAC_SATURATE_EN
                acc = (s > AMAX) ? AMAX : AMIN;
`else
                acc = (s > AMAX) ? s - (64'sd1 <<< ACC_W) : s + (64'sd1 <<< ACC_W);
`endif
            end else begin
                acc = s;
            end
            cnt = (cnt < CMAX) ? cnt + 1 : CMAX;
        end
        c0 = 0;
        foreach (vec_a[i]) begin
            send_beat(vec_a[i], vec_b[i], i == vec_a.size() - 1, c);
            if (i == 0) c0 = c;
            else if (!gaps) chk("throughput", c, c0 + i);
            if (i == vec_a.size() - 1) begin
                e.acc = acc; e.cnt = cnt; e.ovf = ov; e.cyc = c;
                sb.push_back(e);
                @(negedge clk);
                chk("in_ready_low_in_drain", longint'(in_ready), 0);
                @(posedge clk);
                #1;
            end else if (gaps) begin
                repeat ($urandom_range(0, 2)) @(posedge clk);
                #1;
            end
        end
        first_cyc = c0;
        vec_a.delete();
        vec_b.delete();
    endtask

    task automatic wait_drained(input string nm);
        int w = 0;
        while ((sb.size() != 0 || out_valid) && w < 2000) begin
            @(posedge clk);
            w++;
        end
        #1;
        chk(nm, sb.size(), 0);
    endtask

    task automatic check_reset_values(input string nm);
        chk({nm, "_in_ready"}, longint'(in_ready), 1);
        chk({nm, "_out_valid"}, longint'(out_valid), 0);
        chk({nm, "_acc_out"}, longint'(acc_out), 0);
        chk({nm, "_count"}, longint'(count), 0);
        chk({nm, "_overflow"}, longint'(overflow), 0);
    endtask

    initial begin
        int fc, w;
        #3;
        check_reset_values("reset");
        #20;
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        vec_a = '{3};
        vec_b = '{-4};
        run_vector(1'b0, fc);

        vec_a = '{1, 3, -5, 7};
        vec_b = '{2, 4, 6, -8};
        force_stall = 1'b1;
        run_vector(1'b0, fc);
        w = 0;
        while (!out_valid && w < 50) begin
            @(posedge clk);
            w++;
        end
        chk("stall_out_valid_seen", longint'(out_valid), 1);
        repeat (5) @(posedge clk);
        #1;
        force_stall = 1'b0;
        vec_a = '{9, -2};
        vec_b = '{9, 11};
        run_vector(1'b0, fc);
        chk("accept_after_handshake", fc, hs_cyc + 1);
        wait_drained("drain_after_stall");

        for (int v = 0; v < 30; v++) begin
            int n = $urandom_range(1, 8);
            for (int i = 0; i < n; i++) begin
                vec_a.push_back(shortint'($urandom_range(0, 65535)));
                vec_b.push_back(shortint'($urandom_range(0, 65535)));
            end
            run_vector(v[0], fc);
        end
        wait_drained("drain_random");

        for (int i = 0; i < 512; i++) begin
            vec_a.push_back(-16'sd32768);
            vec_b.push_back(-16'sd32768);
        end
        run_vector(1'b0, fc);
        wait_drained("drain_overflow");

        for (int i = 0; i < 2; i++) begin
            send_beat(16'sd100, 16'sd100, 1'b0, fc);
        end
        @(posedge clk);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_values("mid_reset");
        @(negedge clk);
        #2;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        vec_a = '{5};
        vec_b = '{5};
        run_vector(1'b0, fc);
        wait_drained("drain_after_reset");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mac_accumulator.md
# mac_accumulator

Signed multiply-accumulate stage placed directly downstream of the 16x16 combinational `Signed_Multiplier`. It accepts a stream of signed operand pairs over a valid/ready handshake and registers each 32-bit product. It sums the products of one vector, delimited by `last`, into a wide accumulator. It then presents the dot-product result over a second valid/ready handshake.

## Interface
- `ACC_W`, 40: accumulator and result width in bits, signed; minimum 33.
- `CNT_W`, 8: beat-counter width in bits.

- `clk`  in  1  sole clock; all state updates on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset; clears all state.
- `in_valid`  in  1  operand pair `a`, `b` (and `last`) valid.
- `in_ready`  out  1  block can accept a beat this cycle.
- `a`  in  16  signed multiplicand.
- `b`  in  16  signed multiplier.
- `last`  in  1  final beat of the current vector.
- `out_valid`  out  1  `acc_out`, `count` and `overflow` hold a finished result.
- `out_ready`  in  1  downstream consumes the result.
- `acc_out`  out  ACC_W  signed dot-product result.
- `count`  out  CNT_W  beats in the result; saturates at 2^CNT_W-1.
- `overflow`  out  1  sticky: the signed ACC_W range was exceeded during this vector.

## Operation
- A beat is accepted when `in_valid && in_ready`.
- Stage 1: `p_q <= a*b` (32-bit signed), together with `p_valid` and `p_last`.
- Stage 2: `acc <= (first ? 0 : acc) + sext(p_q)`, computed in ACC_W+1 bits.
  - `first` is set at reset and after each result handshake; it is cleared by the first stage-2 add.
- FSM type `mac_state_t`:
  - ACCUM: `in_ready=1`. Moves to DRAIN when a beat with `last=1` is accepted.
  - DRAIN: `in_ready=0`; the stage-2 add of the last beat completes. Moves to HOLD unconditionally after one cycle.
  - HOLD: `in_ready=0`, `out_valid=1`. Moves to ACCUM on `out_valid && out_ready`.
- Sign overflow: the ACC_W+1-bit sum does not fit in ACC_W bits. It sets `overflow`, which stays set until the result is consumed.
- `count` increments on each stage-2 add and saturates at its maximum. It is cleared together with `first`.
- A gap in `in_valid` mid-vector leaves `acc`, `count` and `overflow` untouched.
- A single-beat vector (`last` on its first beat) yields `acc_out = a*b`.
- Extreme operands: -32768 * -32768 = 2^30 is exact in the 32-bit product.
- Reset mid-operation:
  - All state is discarded and the FSM returns to ACCUM.
  - The next vector starts from zero.

## Timing
- Reset values: `in_ready=1`, `out_valid=0`, `acc_out=0`, `count=0`, `overflow=0`. State is ACCUM and `first=1`.
- Throughput: one beat per cycle within a vector.
- Latency: if the last beat is accepted in cycle N, `out_valid` is high from cycle N+2.
- Output stability: while HOLD is stalled, `acc_out`, `count` and `overflow` remain stable.
- Minimum inter-vector bubble: `in_ready` is low for two cycles (DRAIN, then one HOLD cycle with `out_ready=1`).
- The first beat of the next vector can be accepted in the cycle after the output handshake.
- All outputs are registered, except `in_ready`, which decodes from the state register only.
- There are no combinational paths from inputs to outputs.

## Configuration
- `MAC_SATURATE_EN` defined: on overflow, `acc` clamps to the signed ACC_W limit, +(2^(ACC_W-1))-1 or -2^(ACC_W-1). Further adds continue from the clamped value.
- `MAC_SATURATE_EN` undefined: `acc` wraps two's-complement.
- `overflow` is reported identically in both builds.

## Structure
- Package `mac_pkg` holds:
  - `mac_state_t` {ACCUM, DRAIN, HOLD};
  - default `ACC_W` and `CNT_W`;
  - functions `acc_max(w)` and `acc_min(w)` for the saturation limits.
- One sub-module: the existing `Signed_Multiplier` (A, B -> P), instantiated for stage 1. Its output is registered into `p_q`.

## Test plan
- **Single beat:** `a=3`, `b=-4`, `last=1` accepted in cycle 0 -> from cycle 2: `out_valid=1`, `acc_out=-12`, `count=1`, `overflow=0`.
- **Four-beat vector:** pairs (1,2), (3,4), (-5,6), (7,-8) on consecutive cycles -> `acc_out=-72`, `count=4`; `in_ready` low in DRAIN.
- **Backpressure:** hold `out_ready=0` for 5 cycles -> `out_valid` and `acc_out` stable, `in_ready=0`. Raise `out_ready` -> next vector is accepted in the following cycle with `first` honoured (no residue).
- **Overflow:** 512 beats of (-32768,-32768) -> `overflow=1`, `count=255`.
  - With `MAC_SATURATE_EN`: `acc_out = 2^39-1`.
  - Without it: `acc_out = -2^39`.
- **Reset mid-vector:** two beats of (100,100) accepted, then `rst_n` pulsed low mid-cycle -> outputs return to reset values immediately. A subsequent single beat (5,5,`last`) yields `acc_out=25`, `count=1`.
